// File: rtl/muxover_sched.sv
// rtl/muxover_sched.sv - round-robin dwell scheduler for the shared muxover datapath
// Optional: SCHED_LIGHT_PRIORITY_EN gives the traffic-light client fixed priority on ties.
module muxover_sched #(
    parameter int DWELL = 8,
    parameter int GAP   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic req_dice,
    input  logic req_light,
    output logic gnt_dice,
    output logic gnt_light,
    output logic sel,
    output logic button,
    output logic done
);

    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic DICE  = 1'b0;
    localparam logic LIGHT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          gnt_dice_d, gnt_light_d, sel_d, button_d, done_d;
    logic          start;
    logic          winner;

    // Arbitration winner; only meaningful when at least one request is high.
    function automatic logic pick(input logic rd, input logic rl, input logic last);
`ifdef SCHED_LIGHT_PRIORITY_EN
        if (rl)
            return LIGHT;
        else if (rd)
            return DICE;
        else
            return last;
`else
        if (rd && rl)
            return ~last;
        else if (rl)
            return LIGHT;
        else
            return DICE;
`endif
    endfunction

    assign winner = pick(req_dice, req_light, last_owner_q);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        dwell_d      = dwell_q;
        gap_d        = gap_q;
        sel_d        = sel;
        gnt_dice_d   = 1'b0;
        gnt_light_d  = 1'b0;
        button_d     = 1'b0;
        done_d       = 1'b0;
        start        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_dice || req_light)
                    start = 1'b1;
            end
            S_GRANT: begin
                if (dwell_q == '0) begin
                    state_d      = S_GAP;
                    last_owner_d = owner_q;
                    gap_d        = GW'(GAP - 1);
                end else begin
                    dwell_d     = dwell_q - DW'(1);
                    gnt_dice_d  = (owner_q == DICE);
                    gnt_light_d = (owner_q == LIGHT);
                    button_d    = 1'b1;
                    // done is registered, so raise it one cycle ahead of the last dwell cycle
                    done_d      = (dwell_q == DW'(1));
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    if (req_dice || req_light)
                        start = 1'b1;
                    else
                        state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (start) begin
            state_d     = S_GRANT;
            owner_d     = winner;
            sel_d       = winner;
            gnt_dice_d  = (winner == DICE);
            gnt_light_d = (winner == LIGHT);
            button_d    = 1'b1;
            dwell_d     = DW'(DWELL - 1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            owner_q      <= DICE;
            last_owner_q <= LIGHT;
            dwell_q      <= '0;
            gap_q        <= '0;
            gnt_dice     <= 1'b0;
            gnt_light    <= 1'b0;
            sel          <= 1'b0;
            button       <= 1'b0;
            done         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            dwell_q      <= dwell_d;
            gap_q        <= gap_d;
            gnt_dice     <= gnt_dice_d;
            gnt_light    <= gnt_light_d;
            sel          <= sel_d;
            button       <= button_d;
            done         <= done_d;
        end
    end

endmodule
